hi_lo_mul_div: RTL and testbench
================================

HI_LO_MUL_DIV -- requirements
Module: HiLoMulDiv

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Rst  input  1  reset, asynchronous, active-high.
REQ-003 Start  input  1  operation request; sampled only when Busy=0.
REQ-004 Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
REQ-005 OperandA  input  32  rs value: multiplicand, dividend, or MTHI/MTLO source.
REQ-006 OperandB  input  32  rt value: multiplier or divisor.
REQ-007 ReadDataHi  output  32  registered Hi value for the WriteBack HiOrLo path.
REQ-008 ReadDataLo  output  32  registered Lo value for the WriteBack HiOrLo path.
REQ-009 Busy  output  1  iterative operation in flight; the hazard unit stalls MFHI/MFLO and new mult/div while Busy=1.
REQ-010 Done  output  1  one-cycle pulse marking the cycle Hi/Lo first show a new mult/div result.

Function
REQ-011 States: IDLE, MUL, DIV, FIX; 6-bit iteration counter.
REQ-012 IDLE with Start=1 and Op=MTHI/MTLO: Hi (resp. Lo) loads OperandA at that edge; other register unchanged; Busy and Done stay 0.
REQ-013 IDLE with Start=1 and Op=MULT/MULTU/MADD/MSUB: latch operand magnitudes (signed ops take absolute value, record result sign); counter=0; go to MUL.
REQ-014 IDLE with Start=1 and Op=DIV/DIVU: latch magnitudes and quotient/remainder signs; go to DIV.
REQ-015 MUL: one shift-add step per cycle over a 64-bit product register; after 32 steps go to FIX.
REQ-016 DIV: one restoring shift-subtract step per cycle; after 32 steps go to FIX.
REQ-017 FIX: apply two's-complement sign correction; MULT/MULTU write {Hi,Lo}=product; MADD write {Hi,Lo}+product; MSUB write {Hi,Lo}-product (64-bit, wrap modulo 2^64); DIV/DIVU write Lo=quotient, Hi=remainder; go to IDLE.
REQ-018 Signed divide: quotient truncates toward zero; remainder takes dividend sign.
REQ-019 Divide by zero: Lo=32'hFFFFFFFF, Hi=OperandA unchanged; still 34-cycle latency.
REQ-020 Latency: Start in cycle 0 -> Busy=1 in cycles 1-33 -> Hi/Lo updated and Done=1 in cycle 34, Busy=0 in cycle 34.
REQ-021 ReadDataHi/ReadDataLo hold prior values throughout MUL/DIV/FIX; no partial results visible.
REQ-022 Start while Busy=1 is ignored, including MTHI/MTLO; the hazard unit guarantees none is lost.
REQ-023 Start asserted in the Done cycle is accepted normally (back-to-back operations, no idle gap).
REQ-024 Op/operand inputs are don't-care except in the Start acceptance cycle.

Reset
REQ-025 Rst=1 asynchronously forces IDLE, counter=0, Hi=0, Lo=0, Busy=0, Done=0, aborting any operation in flight without a Done pulse.
REQ-026 First Start is accepted at the first rising edge after Rst deasserts.

Configuration
REQ-027 Macro HILO_MULDIV_MADD_EN: defined -> MADD/MSUB behave per REQ-013/REQ-017.
REQ-028 Undefined -> Op 110/111 treated as no-op: Start ignored, no Busy, Hi/Lo unchanged; accumulate adder logic absent.

Verification
REQ-029 MULT A=-3 (32'hFFFFFFFD), B=7 -> cycle 34: Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB, Done=1 for exactly one cycle.
REQ-030 MULTU A=B=32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=32'h00000001.
REQ-031 DIV A=-7, B=2 -> Lo=32'hFFFFFFFD (-3), Hi=32'hFFFFFFFF (-1); DIVU A=5, B=0 -> Lo=32'hFFFFFFFF, Hi=5.
REQ-032 MTHI 32'h12345678, then MULT started, then Start with MTLO in cycle 10 -> MTLO ignored, Hi=32'h12345678 until cycle 34 result overwrites it.
REQ-033 DIV started, Rst pulsed in cycle 20 -> Hi=Lo=0, Busy=0 immediately, no Done; next MULTU 6x7 -> Lo=42 in cycle 34 after its Start.
REQ-034 With macro: Hi=0, Lo=10, MADD 3x4 -> Lo=22; MSUB 5x5 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF; without macro: same Start -> Busy stays 0, Hi/Lo unchanged.

Source files
------------

// File: rtl/hi_lo_mul_div.sv
// Hi/Lo register file with iterative 32-cycle multiply and restoring divide.
// HILO_MULDIV_MADD_EN enables the MADD/MSUB accumulate ops (Op 110/111).
module hi_lo_mul_div (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  output logic [31:0] ReadDataHi,
  output logic [31:0] ReadDataLo,
  output logic        Busy,
  output logic        Done
);

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
`ifdef HILO_MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD = 3'b110;
  localparam logic [2:0] OP_MSUB = 3'b111;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] mb_q, mb_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic        div_q, div_d;
`ifdef HILO_MULDIV_MADD_EN
  logic        madd_q, madd_d;
  logic        msub_q, msub_d;
`endif

  logic        sgn_op;
  logic        is_mul;
  logic        is_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ok;
  logic [31:0] div_rem;
  logic [63:0] prod_fix;
  logic [63:0] mul_res;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

`ifdef HILO_MULDIV_MADD_EN
  assign sgn_op = (Op == OP_MULT) | (Op == OP_DIV)
                | (Op == OP_MADD) | (Op == OP_MSUB);
  assign is_mul = (Op[2:1] == 2'b00) | (Op[2:1] == 2'b11);
`else
  assign sgn_op = (Op == OP_MULT) | (Op == OP_DIV);
  assign is_mul = (Op[2:1] == 2'b00);
`endif
  assign is_div = (Op[2:1] == 2'b01);

  assign a_neg = sgn_op & OperandA[31];
  assign b_neg = sgn_op & OperandB[31];
  assign abs_a = a_neg ? -OperandA : OperandA;
  assign abs_b = b_neg ? -OperandB : OperandB;

  // Multiplier bits drain from the low half as the sum fills the high half.
  assign mul_sum = {1'b0, prod_q[63:32]}
                 + (prod_q[0] ? {1'b0, mb_q} : 33'd0);

  // Divide reuses prod_q as {remainder, dividend/quotient}.
  assign div_sh  = {prod_q[63:32], prod_q[31]};
  assign div_ok  = div_sh >= {1'b0, mb_q};
  assign div_rem = div_ok ? (div_sh[31:0] - mb_q) : div_sh[31:0];

  assign prod_fix = neg_q ? -prod_q : prod_q;
  assign quo_fix  = dz_q ? 32'hFFFF_FFFF
                  : (neg_q ? -prod_q[31:0] : prod_q[31:0]);
  assign rem_fix  = rneg_q ? -prod_q[63:32] : prod_q[63:32];

`ifdef HILO_MULDIV_MADD_EN
  always_comb begin
    mul_res = prod_fix;
    if (madd_q)
      mul_res = {hi_q, lo_q} + prod_fix;
    else if (msub_q)
      mul_res = {hi_q, lo_q} - prod_fix;
  end
`else
  assign mul_res = prod_fix;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    div_d   = div_q;
`ifdef HILO_MULDIV_MADD_EN
    madd_d  = madd_q;
    msub_d  = msub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Op == OP_MTHI) begin
            hi_d = OperandA;
          end else if (Op == OP_MTLO) begin
            lo_d = OperandA;
          end else if (is_mul) begin
            prod_d  = {32'd0, abs_b};
            mb_d    = abs_a;
            neg_d   = a_neg ^ b_neg;
            div_d   = 1'b0;
            cnt_d   = 6'd0;
            busy_d  = 1'b1;
            state_d = S_MUL;
`ifdef HILO_MULDIV_MADD_EN
            madd_d  = (Op == OP_MADD);
            msub_d  = (Op == OP_MSUB);
`endif
          end else if (is_div) begin
            prod_d  = {32'd0, abs_a};
            mb_d    = abs_b;
            dz_d    = (OperandB == 32'd0);
            neg_d   = (a_neg ^ b_neg) & (OperandB != 32'd0);
            rneg_d  = a_neg;
            div_d   = 1'b1;
            cnt_d   = 6'd0;
            busy_d  = 1'b1;
            state_d = S_DIV;
`ifdef HILO_MULDIV_MADD_EN
            madd_d  = 1'b0;
            msub_d  = 1'b0;
`endif
          end
        end
      end
      S_MUL: begin
        prod_d = {mul_sum, prod_q[31:1]};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31)
          state_d = S_FIX;
      end
      S_DIV: begin
        prod_d = {div_rem, prod_q[30:0], div_ok};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31)
          state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = mul_res[63:32];
          lo_d = mul_res[31:0];
        end
        cnt_d   = 6'd0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= 64'd0;
      mb_q    <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
`ifdef HILO_MULDIV_MADD_EN
      madd_q  <= 1'b0;
      msub_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
`ifdef HILO_MULDIV_MADD_EN
      madd_q  <= madd_d;
      msub_q  <= msub_d;
`endif
    end
  end

  assign ReadDataHi = hi_q;
  assign ReadDataLo = lo_q;
  assign Busy       = busy_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_hi_lo_mul_div.sv
// Directed bench for hi_lo_mul_div; outputs sampled on the falling edge.
// MADD/MSUB steps follow HILO_MULDIV_MADD_EN like the design.
module tb_hi_lo_mul_div;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic [31:0] ReadDataHi;
  logic [31:0] ReadDataLo;
  logic        Busy;
  logic        Done;

  int n_cmp = 0;
  int n_err = 0;

  hi_lo_mul_div dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Op         (Op),
    .OperandA   (OperandA),
    .OperandB   (OperandB),
    .ReadDataHi (ReadDataHi),
    .ReadDataLo (ReadDataLo),
    .Busy       (Busy),
    .Done       (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    Start    = 1'b1;
    Op       = op;
    OperandA = a;
    OperandB = b;
    @(negedge Clk);
    Start    = 1'b0;
    OperandA = 32'hx;
    OperandB = 32'hx;
  endtask

  task automatic chk_result(input string tag,
                            input logic [31:0] hi,
                            input logic [31:0] lo);
    chk({tag, "_hi"}, ReadDataHi, hi);
    chk({tag, "_lo"}, ReadDataLo, lo);
    chk({tag, "_done"}, {31'd0, Done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    Rst      = 1'b1;
    Start    = 1'b0;
    Op       = 3'b000;
    OperandA = 32'd0;
    OperandB = 32'd0;
    repeat (2) @(negedge Clk);
    chk("rst_hi", ReadDataHi, 32'd0);
    chk("rst_lo", ReadDataLo, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);

    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_hi", ReadDataHi, 32'h1234_5678);
    chk("mthi_lo", ReadDataLo, 32'd0);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    chk("mthi_done", {31'd0, Done}, 32'd0);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    chk("mult_c1_busy", {31'd0, Busy}, 32'd1);
    repeat (9) @(negedge Clk);
    Start    = 1'b1;
    Op       = OP_MTLO;
    OperandA = 32'hDEAD_BEEF;
    @(negedge Clk);
    Start = 1'b0;
    chk("mtlo_ign_lo", ReadDataLo, 32'd0);
    chk("mtlo_ign_hi", ReadDataHi, 32'h1234_5678);
    repeat (22) @(negedge Clk);
    chk("mult_c33_busy", {31'd0, Busy}, 32'd1);
    chk("mult_c33_done", {31'd0, Done}, 32'd0);
    chk("mult_c33_hi", ReadDataHi, 32'h1234_5678);
    @(negedge Clk);
    chk_result("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b_done_low", {31'd0, Done}, 32'd0);
    chk("b2b_busy", {31'd0, Busy}, 32'd1);
    repeat (33) @(negedge Clk);
    chk_result("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (33) @(negedge Clk);
    chk_result("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    repeat (33) @(negedge Clk);
    chk_result("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD);

    issue(OP_DIVU, 32'hFFFF_FFF0, 32'd16);
    repeat (33) @(negedge Clk);
    chk_result("divu_big", 32'h0000_0000, 32'h0FFF_FFFF);

    issue(OP_DIVU, 32'd5, 32'd0);
    repeat (32) @(negedge Clk);
    chk("divz_c33_busy", {31'd0, Busy}, 32'd1);
    @(negedge Clk);
    chk_result("divu_z", 32'd5, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'hFFFF_FFF8, 32'd0);
    repeat (33) @(negedge Clk);
    chk_result("div_z_neg", 32'hFFFF_FFF8, 32'hFFFF_FFFF);

    issue(OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (33) @(negedge Clk);
    chk_result("mult_min", 32'h0000_0000, 32'h8000_0000);

    issue(OP_MTHI, 32'hFFFF_FFF8, 32'd0);
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (19) @(negedge Clk);
    chk("abort_hold_hi", ReadDataHi, 32'hFFFF_FFF8);
    Rst = 1'b1;
    #1;
    chk("abort_hi", ReadDataHi, 32'd0);
    chk("abort_lo", ReadDataLo, 32'd0);
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    chk("abort_done", {31'd0, Done}, 32'd0);
    issue(OP_MULTU, 32'd6, 32'd7);
    chk("post_rst_busy", {31'd0, Busy}, 32'd1);
    repeat (33) @(negedge Clk);
    chk_result("post_rst_mul", 32'd0, 32'd42);
    @(negedge Clk);
    chk("done_one_cycle", {31'd0, Done}, 32'd0);

`ifdef HILO_MULDIV_MADD_EN
    issue(OP_MTLO, 32'd10, 32'd0);
    issue(OP_MADD, 32'd3, 32'd4);
    repeat (33) @(negedge Clk);
    chk_result("madd", 32'd0, 32'd22);
    issue(OP_MSUB, 32'd5, 32'd5);
    repeat (33) @(negedge Clk);
    chk_result("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(OP_MADD, 32'hFFFF_FFFE, 32'd3);
    repeat (33) @(negedge Clk);
    chk_result("madd_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF7);
`else
    issue(OP_MADD, 32'd3, 32'd4);
    chk("nomadd_busy", {31'd0, Busy}, 32'd0);
    chk("nomadd_hi", ReadDataHi, 32'd0);
    chk("nomadd_lo", ReadDataLo, 32'd42);
    issue(OP_MSUB, 32'd5, 32'd5);
    chk("nomsub_busy", {31'd0, Busy}, 32'd0);
    repeat (34) @(negedge Clk);
    chk("nomsub_done", {31'd0, Done}, 32'd0);
    chk("nomsub_lo", ReadDataLo, 32'd42);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
